// File: rtl/inport_pkg.sv
// Shared constants and helpers for the switch/pushbutton input peripheral.
package inport_pkg;

  localparam logic [1:0] REG_SW   = 2'd0;
  localparam logic [1:0] REG_KEY  = 2'd1;
  localparam logic [1:0] REG_EDGE = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int unsigned NUM_KEYS = 4;
  localparam int unsigned NUM_SW   = 10;

  // Bits needed to count 0..value-1; never less than one.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((w < 32) && ((32'd1 << w) < value)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton debounce cell: accepts a level change only after DEB_CYCLES
// consecutive cycles of disagreement; flags the accepted press in that cycle.
module key_debounce
  import inport_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sync,
  output logic lvl,
  output logic rise_c
);

  localparam int unsigned CNT_W = clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign rise_c = sync && !lvl && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl <= 1'b0;
      cnt <= '0;
    end else if (sync == lvl) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      lvl <= sync;
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/inport_ctrl.sv
// Memory-mapped SW/KEY input port: sync, debounce, sticky press edges, 1-cycle reads.
// Optional INPORT_IRQ_EN adds a press mask at index 3 and a registered IRQ.
module inport_ctrl
  import inport_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter logic [3:0]  BASE_HI    = 4'h3,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [NUM_SW-1:0]   SW,
  input  logic [NUM_KEYS-1:0] KEY,
  input  logic [DATA_W-1:0]   ADDR,
  input  logic                RD,
  input  logic                W,
  input  logic [DATA_W-1:0]   DOUT,
  output logic [DATA_W-1:0]   RDATA,
  output logic                RVALID,
  output logic                IRQ
);

  logic [NUM_SW-1:0]   sw_s1, sw_s2;
  logic [NUM_KEYS-1:0] key_s1, key_s2;
  logic [NUM_KEYS-1:0] ksync, lvl, rise_c, key_edge, mask, clr_c;
  logic                cs_c;
  logic [1:0]          idx_c;
  logic [DATA_W-1:0]   rd_val_c;
  logic                unused_bits;

  // Two-flop synchronisers; keys idle released (high) out of reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      key_s1 <= '1;
      key_s2 <= '1;
    end else begin
      sw_s1  <= SW;
      sw_s2  <= sw_s1;
      key_s1 <= KEY;
      key_s2 <= key_s1;
    end
  end

  assign ksync = ~key_s2;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_deb
    key_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk   (Clock),
      .rst   (Reset),
      .sync  (ksync[i]),
      .lvl   (lvl[i]),
      .rise_c(rise_c[i])
    );
  end

  assign cs_c  = (ADDR[15:12] == BASE_HI);
  assign idx_c = ADDR[1:0];
  assign clr_c = (W && cs_c && (idx_c == REG_EDGE)) ? DOUT[NUM_KEYS-1:0] : '0;

  // Sticky press edges; a same-cycle press beats the write-1-to-clear.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      key_edge <= '0;
    end else begin
      key_edge <= (key_edge & ~clr_c) | rise_c;
    end
  end

`ifdef INPORT_IRQ_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      mask <= '0;
    end else if (W && cs_c && (idx_c == REG_CTRL)) begin
      mask <= DOUT[NUM_KEYS-1:0];
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      IRQ <= 1'b0;
    end else begin
      IRQ <= |(key_edge & mask);
    end
  end
`else
  assign mask = '0;
  assign IRQ  = 1'b0;
`endif

  always_comb begin
    rd_val_c = '0;
    case (idx_c)
      REG_SW:   rd_val_c = DATA_W'(sw_s2);
      REG_KEY:  rd_val_c = DATA_W'(lvl);
      REG_EDGE: rd_val_c = DATA_W'(key_edge);
      REG_CTRL: rd_val_c = DATA_W'({|key_edge, mask});
      default:  rd_val_c = '0;
    endcase
  end

  // Read data is zero whenever no response is being returned.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      RDATA  <= '0;
      RVALID <= 1'b0;
    end else begin
      RVALID <= RD && cs_c;
      RDATA  <= (RD && cs_c) ? rd_val_c : '0;
    end
  end

  // Address bits [11:2] alias; upper write-data bits carry nothing here.
  assign unused_bits = ^{ADDR[11:2], DOUT[DATA_W-1:NUM_KEYS]};

endmodule
